// File: rtl/matmul_pkg.sv
// Shared parameters, register map and helpers for the matmul accelerator APB front end.
package matmul_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int BUS_WIDTH  = 32;
   localparam int ADDR_WIDTH = 16;
   localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
   localparam int ROW_W      = $clog2(MAX_DIM);
   localparam int SP_DEPTH   = MAX_DIM * MAX_DIM;
   localparam int SP_AW      = $clog2(SP_DEPTH);

   localparam logic [4:0] CONTROL   = 5'b00000;
   localparam logic [4:0] OPERAND_A = 5'b00100;
   localparam logic [4:0] OPERAND_B = 5'b01000;
   localparam logic [4:0] FLAGS     = 5'b01100;
   localparam logic [4:0] SP        = 5'b10000;

   localparam int                   CTRL_START      = 0;
   localparam logic [BUS_WIDTH-1:0] CTRL_START_MASK = BUS_WIDTH'(1) << CTRL_START;

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} apb_state_t;

   // Merge only the strobed byte lanes of new_v into old_v.
   function automatic logic [BUS_WIDTH-1:0] apply_strb(input logic [BUS_WIDTH-1:0] old_v,
                                                       input logic [BUS_WIDTH-1:0] new_v,
                                                       input logic [MAX_DIM-1:0]   strb);
      logic [BUS_WIDTH-1:0] res;
      res = old_v;
      for (int k = 0; k < MAX_DIM; k++) begin
         if (strb[k]) res[k*DATA_WIDTH +: DATA_WIDTH] = new_v[k*DATA_WIDTH +: DATA_WIDTH];
      end
      return res;
   endfunction

endpackage

// File: rtl/matmul_sp_mem.sv
// Result scratchpad: core write port plus a registered APB read port (read-before-write).
module matmul_sp_mem
   import matmul_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 we_i,
   input  logic [SP_AW-1:0]     waddr_i,
   input  logic [BUS_WIDTH-1:0] wdata_i,
   input  logic                 re_i,
   input  logic [SP_AW-1:0]     raddr_i,
   output logic [BUS_WIDTH-1:0] rdata_o
);

   logic [BUS_WIDTH-1:0] mem_q [SP_DEPTH];

   // A read of the element written on the same edge sees the old contents.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SP_DEPTH; i++) mem_q[i] <= '0;
         rdata_o <= '0;
      end else begin
         if (we_i) mem_q[waddr_i] <= wdata_i;
         if (re_i) rdata_o <= mem_q[raddr_i];
      end
   end

endmodule

// File: rtl/matmul_apb_slave.sv
// APB responder and register file for the matmul core: operands, control, flags, scratchpad.
module matmul_apb_slave
   import matmul_pkg::*;
(
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         psel_i,
   input  logic                         penable_i,
   input  logic                         pwrite_i,
   input  logic [MAX_DIM-1:0]           pstrb_i,
   input  logic [BUS_WIDTH-1:0]         pwdata_i,
   input  logic [ADDR_WIDTH-1:0]        paddr_i,
   output logic                         pready_o,
   output logic                         pslverr_o,
   output logic [BUS_WIDTH-1:0]         prdata_o,
   output logic                         busy_o,
   output logic                         start_o,
   output logic [BUS_WIDTH-1:0]         ctrl_o,
   output logic [MAX_DIM*BUS_WIDTH-1:0] a_mat_o,
   output logic [MAX_DIM*BUS_WIDTH-1:0] b_mat_o,
   input  logic                         done_i,
   input  logic [BUS_WIDTH-1:0]         flags_i,
   input  logic                         sp_we_i,
   input  logic [SP_AW-1:0]             sp_addr_i,
   input  logic [BUS_WIDTH-1:0]         sp_wdata_i
);

   // Handshake: the access phase is the cycle after psel_i is seen in IDLE. Writes finish
   // there with pready_o=1; reads add one wait state (RDWAIT). psel_i low aborts silently.
   apb_state_t state_q, state_d;

   logic [BUS_WIDTH-1:0] ctrl_q, flags_q, rdata_q, rd_mux, sp_rdata;
   logic [BUS_WIDTH-1:0] a_q [MAX_DIM];
   logic [BUS_WIDTH-1:0] b_q [MAX_DIM];
   logic                 busy_q, start_q, rd_err_q, rd_sp_q;

   logic [4:0]       reg_sel;
   logic [ROW_W-1:0] row;
   logic [SP_AW-1:0] sp_idx;
   logic is_ctrl, is_a, is_b, is_flags, is_sp, row_oob, acc_err, wr_err;
   logic wr_fire, rd_fire, wr_ok, start_set;

   assign reg_sel  = paddr_i[4:0];
   assign row      = paddr_i[5 +: ROW_W];
   assign sp_idx   = paddr_i[5 +: SP_AW];
   assign is_ctrl  = (reg_sel == CONTROL);
   assign is_a     = (reg_sel == OPERAND_A);
   assign is_b     = (reg_sel == OPERAND_B);
   assign is_flags = (reg_sel == FLAGS);
   assign is_sp    = (reg_sel == SP);
   // Any address bit above the row field means a row index >= MAX_DIM.
   assign row_oob  = (is_a | is_b) & (|paddr_i[ADDR_WIDTH-1:5+ROW_W]);
   assign acc_err  = ~(is_ctrl | is_a | is_b | is_flags | is_sp) | row_oob;
   assign wr_err   = acc_err | is_flags | is_sp | (busy_q & (is_ctrl | is_a | is_b));

   assign wr_fire   = (state_q == ACCESS) & psel_i & pwrite_i;
   assign rd_fire   = (state_q == ACCESS) & psel_i & ~pwrite_i;
   assign wr_ok     = wr_fire & ~wr_err;
   assign start_set = wr_ok & is_ctrl & pstrb_i[CTRL_START/DATA_WIDTH] & pwdata_i[CTRL_START];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      pready_o  = 1'b0;
      pslverr_o = 1'b0;
      prdata_o  = '0;
      case (state_q)
         IDLE:   if (psel_i) state_d = ACCESS;
         ACCESS: begin
            if (!psel_i) state_d = IDLE;
            else if (pwrite_i) begin
               state_d   = IDLE;
               pready_o  = 1'b1;
               pslverr_o = wr_err;
            end else state_d = RDWAIT;
         end
         RDWAIT: begin
            state_d = IDLE;
            if (psel_i) begin
               pready_o  = 1'b1;
               pslverr_o = rd_err_q;
               prdata_o  = rd_sp_q ? sp_rdata : rdata_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         CONTROL:   rd_mux = ctrl_q;
         OPERAND_A: rd_mux = a_q[row];
         OPERAND_B: rd_mux = b_q[row];
         FLAGS:     rd_mux = flags_q;
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q   <= '0;
         flags_q  <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         start_q  <= 1'b0;
         rd_err_q <= 1'b0;
         rd_sp_q  <= 1'b0;
         for (int r = 0; r < MAX_DIM; r++) begin
            a_q[r] <= '0;
            b_q[r] <= '0;
         end
      end else begin
         if (wr_ok && is_ctrl) ctrl_q <= apply_strb(ctrl_q, pwdata_i, pstrb_i) & ~CTRL_START_MASK;
         if (wr_ok && is_a)    a_q[row] <= apply_strb(a_q[row], pwdata_i, pstrb_i);
         if (wr_ok && is_b)    b_q[row] <= apply_strb(b_q[row], pwdata_i, pstrb_i);
         if (done_i)           flags_q <= flags_i;
         start_q <= start_set;
         if (start_set)   busy_q <= 1'b1;
         else if (done_i) busy_q <= 1'b0;
         if (rd_fire) begin
            rdata_q  <= acc_err ? '0 : rd_mux;
            rd_err_q <= acc_err;
            rd_sp_q  <= is_sp;
         end
      end
   end

   matmul_sp_mem u_sp_mem (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (sp_we_i),
      .waddr_i (sp_addr_i),
      .wdata_i (sp_wdata_i),
      .re_i    (rd_fire & is_sp),
      .raddr_i (sp_idx),
      .rdata_o (sp_rdata)
   );

   always_comb begin
      a_mat_o = '0;
      b_mat_o = '0;
      for (int r = 0; r < MAX_DIM; r++) begin
         a_mat_o[r*BUS_WIDTH +: BUS_WIDTH] = a_q[r];
         b_mat_o[r*BUS_WIDTH +: BUS_WIDTH] = b_q[r];
      end
   end

   assign busy_o  = busy_q;
   assign start_o = start_q;
   assign ctrl_o  = ctrl_q;

   // penable_i is implied by the FSM position; it is not needed for decode.
   logic unused_penable;
   assign unused_penable = penable_i;

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed bench for matmul_apb_slave: register map, strobes, start/busy, errors, SP, reset.
module tb_matmul_apb_slave;
   import matmul_pkg::*;

   logic                         clk_i = 1'b0;
   logic                         rst_ni = 1'b0;
   logic                         psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
   logic [MAX_DIM-1:0]           pstrb_i = '0;
   logic [BUS_WIDTH-1:0]         pwdata_i = '0;
   logic [ADDR_WIDTH-1:0]        paddr_i = '0;
   logic                         pready_o, pslverr_o, busy_o, start_o;
   logic [BUS_WIDTH-1:0]         prdata_o, ctrl_o;
   logic [MAX_DIM*BUS_WIDTH-1:0] a_mat_o, b_mat_o;
   logic                         done_i = 1'b0;
   logic [BUS_WIDTH-1:0]         flags_i = '0;
   logic                         sp_we_i = 1'b0;
   logic [SP_AW-1:0]             sp_addr_i = '0;
   logic [BUS_WIDTH-1:0]         sp_wdata_i = '0;

   int n_vec  = 0;
   int n_miss = 0;

   logic [BUS_WIDTH-1:0] rd;
   logic                 err;
   int                   lat;

   always #5 clk_i = ~clk_i;

   matmul_apb_slave dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
      .pwrite_i(pwrite_i), .pstrb_i(pstrb_i), .pwdata_i(pwdata_i), .paddr_i(paddr_i),
      .pready_o(pready_o), .pslverr_o(pslverr_o), .prdata_o(prdata_o), .busy_o(busy_o),
      .start_o(start_o), .ctrl_o(ctrl_o), .a_mat_o(a_mat_o), .b_mat_o(b_mat_o),
      .done_i(done_i), .flags_i(flags_i), .sp_we_i(sp_we_i), .sp_addr_i(sp_addr_i),
      .sp_wdata_i(sp_wdata_i)
   );

   task automatic check_val(input string tag, input logic [BUS_WIDTH-1:0] got,
                            input logic [BUS_WIDTH-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One APB transfer; lat counts access-phase cycles until pready_o (0 on timeout).
   task automatic apb_xfer(input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                           input logic [BUS_WIDTH-1:0] data, input logic [MAX_DIM-1:0] strb,
                           output logic [BUS_WIDTH-1:0] rdata, output logic serr, output int nlat);
      bit done = 0;
      int n = 0;
      rdata = '0; serr = 1'b0; nlat = 0;
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
      paddr_i = addr; pwdata_i = data; pstrb_i = strb;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      while (!done && n < 16) begin
         @(negedge clk_i);
         n++;
         if (pready_o) begin
            done = 1; serr = pslverr_o; rdata = prdata_o; nlat = n;
         end
      end
      if (!done) check_val("pready_timeout", 32'd0, 32'd1);
      @(posedge clk_i); #1;
      psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; pstrb_i = '0;
   endtask

   initial begin
      #2;
      check_val("rst_pready", {31'd0, pready_o}, 32'd0);
      check_val("rst_busy",   {31'd0, busy_o},   32'd0);
      check_val("rst_start",  {31'd0, start_o},  32'd0);
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      apb_xfer(1'b0, 16'h0000, '0, '0, rd, err, lat);
      check_val("ctrl_rd_data", rd, 32'h0);
      check_val("ctrl_rd_err",  {31'd0, err}, 32'd0);
      check_val("rd_latency",   lat, 32'd2);

      // OPERAND_A row 2, lanes 0 and 2 only
      apb_xfer(1'b1, 16'h0044, 32'hAABBCCDD, 4'b0101, rd, err, lat);
      check_val("a2_wr_err", {31'd0, err}, 32'd0);
      check_val("wr_latency", lat, 32'd1);
      apb_xfer(1'b0, 16'h0044, '0, '0, rd, err, lat);
      check_val("a2_rd", rd, 32'h00BB00DD);
      check_val("a2_mat", a_mat_o[95:64], 32'h00BB00DD);

      apb_xfer(1'b1, 16'h0024, 32'h12345678, 4'b0000, rd, err, lat);
      check_val("strb0_err", {31'd0, err}, 32'd0);
      apb_xfer(1'b0, 16'h0024, '0, '0, rd, err, lat);
      check_val("strb0_rd", rd, 32'h0);

      apb_xfer(1'b1, 16'h0008, 32'h11223344, 4'b1111, rd, err, lat);
      check_val("b0_wr_err", {31'd0, err}, 32'd0);
      check_val("b0_mat", b_mat_o[31:0], 32'h11223344);

      // START with extra control bits; START itself must not stick
      apb_xfer(1'b1, 16'h0000, 32'h00000301, 4'b1111, rd, err, lat);
      check_val("start_wr_err", {31'd0, err}, 32'd0);
      check_val("start_pulse",  {31'd0, start_o}, 32'd1);
      check_val("busy_set",     {31'd0, busy_o},  32'd1);
      @(posedge clk_i); #1;
      check_val("start_one_cycle", {31'd0, start_o}, 32'd0);
      check_val("busy_held",       {31'd0, busy_o},  32'd1);
      apb_xfer(1'b0, 16'h0000, '0, '0, rd, err, lat);
      check_val("ctrl_readback", rd, 32'h00000300);
      check_val("ctrl_o", ctrl_o, 32'h00000300);

      apb_xfer(1'b1, 16'h0008, 32'hDEADBEEF, 4'b1111, rd, err, lat);
      check_val("b0_busy_err", {31'd0, err}, 32'd1);
      apb_xfer(1'b0, 16'h0008, '0, '0, rd, err, lat);
      check_val("b0_busy_rd", rd, 32'h11223344);
      check_val("b0_busy_rd_err", {31'd0, err}, 32'd0);
      apb_xfer(1'b1, 16'h0000, 32'h00000001, 4'b1111, rd, err, lat);
      check_val("ctrl_busy_err", {31'd0, err}, 32'd1);
      check_val("ctrl_busy_start", {31'd0, start_o}, 32'd0);

      @(posedge clk_i); #1;
      done_i = 1'b1; flags_i = 32'h5;
      @(posedge clk_i); #1;
      done_i = 1'b0; flags_i = '0;
      check_val("busy_clear", {31'd0, busy_o}, 32'd0);
      apb_xfer(1'b0, 16'h000C, '0, '0, rd, err, lat);
      check_val("flags_rd", rd, 32'h5);
      apb_xfer(1'b1, 16'h000C, 32'hFFFFFFFF, 4'b1111, rd, err, lat);
      check_val("flags_wr_err", {31'd0, err}, 32'd1);

      @(posedge clk_i); #1;
      sp_we_i = 1'b1; sp_addr_i = 4'd6; sp_wdata_i = 32'hFFFFFF9C;
      @(posedge clk_i); #1;
      sp_we_i = 1'b0;
      apb_xfer(1'b0, 16'h00D0, '0, '0, rd, err, lat);
      check_val("sp6_rd", rd, 32'hFFFFFF9C);
      check_val("sp6_rd_err", {31'd0, err}, 32'd0);
      apb_xfer(1'b1, 16'h00D0, 32'h0, 4'b1111, rd, err, lat);
      check_val("sp6_wr_err", {31'd0, err}, 32'd1);
      apb_xfer(1'b0, 16'h00D0, '0, '0, rd, err, lat);
      check_val("sp6_unchanged", rd, 32'hFFFFFF9C);
      apb_xfer(1'b0, 16'h0030, '0, '0, rd, err, lat);
      check_val("sp1_rd", rd, 32'h0);

      apb_xfer(1'b0, 16'h0014, '0, '0, rd, err, lat);
      check_val("unmapped_rd_err", {31'd0, err}, 32'd1);
      apb_xfer(1'b1, 16'h0014, 32'h1, 4'b1111, rd, err, lat);
      check_val("unmapped_wr_err", {31'd0, err}, 32'd1);
      apb_xfer(1'b1, 16'h0084, 32'hCAFEF00D, 4'b1111, rd, err, lat);
      check_val("row4_wr_err", {31'd0, err}, 32'd1);
      check_val("row0_intact", a_mat_o[31:0], 32'h0);
      apb_xfer(1'b0, 16'h0088, '0, '0, rd, err, lat);
      check_val("row4_rd_err", {31'd0, err}, 32'd1);

      // Reset while a read sits in its wait state
      @(posedge clk_i); #1;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 16'h0044;
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      @(posedge clk_i); #1;
      check_val("rdwait_ready", {31'd0, pready_o}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      check_val("async_rst_pready", {31'd0, pready_o}, 32'd0);
      check_val("async_rst_prdata", prdata_o, 32'h0);
      check_val("async_rst_a2", a_mat_o[95:64], 32'h0);
      check_val("async_rst_ctrl", ctrl_o, 32'h0);
      psel_i = 1'b0; penable_i = 1'b0;
      @(posedge clk_i); #1 rst_ni = 1'b1;
      apb_xfer(1'b0, 16'h000C, '0, '0, rd, err, lat);
      check_val("post_rst_flags", rd, 32'h0);
      check_val("post_rst_lat", lat, 32'd2);
      apb_xfer(1'b0, 16'h00D0, '0, '0, rd, err, lat);
      check_val("post_rst_sp6", rd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/matmul_apb_slave.md
Name: matmul_apb_slave

Overview:
- APB responder and register file of the matmul accelerator; the counterpart of the bench-side APB initiator.
- Decodes CONTROL, OPERAND_A, OPERAND_B, FLAGS and SP accesses and applies byte strobes.
- Holds the operand matrices and the result scratchpad (SP).
- Hands start and control to the compute core, and reports busy and errors back on APB.

Parameters:
- DATA_WIDTH, 8, operand element width (one byte lane).
- BUS_WIDTH, 32, APB data width and SP element width.
- ADDR_WIDTH, 16, APB address width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH = 4, max matrix dimension; number of pstrb lanes.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  1=write, 0=read
- pstrb_i  in  MAX_DIM  byte-lane write strobes
- pwdata_i  in  BUS_WIDTH  write data
- paddr_i  in  ADDR_WIDTH  address
- pready_o  out  1  transfer complete
- pslverr_o  out  1  transfer error, valid only with pready_o
- prdata_o  out  BUS_WIDTH  read data
- busy_o  out  1  computation in progress
- start_o  out  1  one-cycle start pulse to core
- ctrl_o  out  BUS_WIDTH  CONTROL register contents
- a_mat_o  out  MAX_DIM*BUS_WIDTH  operand A rows, row r at [r*BUS_WIDTH +: BUS_WIDTH]
- b_mat_o  out  MAX_DIM*BUS_WIDTH  operand B rows, same packing
- done_i  in  1  core finished (single-cycle pulse)
- flags_i  in  BUS_WIDTH  core status flags
- sp_we_i  in  1  core SP write enable
- sp_addr_i  in  $clog2(MAX_DIM*MAX_DIM)  SP element index i*MAX_DIM+j
- sp_wdata_i  in  BUS_WIDTH  result element

Behaviour:
- Decode:
  - paddr_i[4:0]: CONTROL=00000, OPERAND_A=00100, OPERAND_B=01000, FLAGS=01100, SP=10000.
  - Operands: row index = paddr_i[5 +: $clog2(MAX_DIM)].
  - SP: element index = paddr_i[5 +: 2*$clog2(MAX_DIM)].
- FSM IDLE/ACCESS/RDWAIT:
  - IDLE -> ACCESS on psel_i.
  - Write in ACCESS: completes the same cycle (pready_o=1, zero wait), then -> IDLE.
  - Read in ACCESS: -> RDWAIT, data is registered; next cycle pready_o=1 with prdata_o valid, then -> IDLE (one wait state).
  - psel_i dropping mid-transfer: abort to IDLE, no side effects.
- Writes: only lanes with pstrb_i[k]=1 update bits [k*DATA_WIDTH +: DATA_WIDTH]; pstrb_i=0 is legal with no update and no error.
- CONTROL bit0 = START:
  - Writing 1 while not busy: start_o pulses for exactly one cycle after the write completes; busy_o sets the same cycle.
  - START is self-clearing and reads back 0.
  - busy_o clears on the cycle after done_i; FLAGS latches flags_i on done_i.
- pslverr_o=1 (register unchanged) for any of:
  - write to FLAGS or SP (read-only);
  - write to CONTROL, OPERAND_A or OPERAND_B while busy_o=1;
  - unmapped paddr_i[4:0];
  - row index >= MAX_DIM on an operand access.
- Reads while busy are permitted.
- SP ownership:
  - Core writes via sp_we_i have priority.
  - An APB read of the element being written in the same cycle returns the old value.
- done_i with busy_o=0 is ignored, except that FLAGS still latches.
- Reset (asynchronous, any time including mid-transfer):
  - FSM=IDLE; pready_o, pslverr_o, prdata_o, busy_o, start_o = 0.
  - All registers, operands, FLAGS and SP = 0.
- All stored values are unsigned bit copies; no arithmetic in this block.

Decomposition:
- matmul_pkg holds:
  - DATA_WIDTH, BUS_WIDTH, ADDR_WIDTH, MAX_DIM;
  - address constants CONTROL, OPERAND_A, OPERAND_B, FLAGS, SP;
  - apb_state_t enum (IDLE, ACCESS, RDWAIT);
  - CONTROL bit-position constants.
- One sub-module, matmul_sp_mem: MAX_DIM*MAX_DIM x BUS_WIDTH array with one core write port and one registered APB read port.

Test Plan:
- Reset then read CONTROL -> pready_o on the 2nd ACCESS cycle, prdata_o=0, pslverr_o=0.
- Write OPERAND_A row 2 with pwdata_i=0xAABBCCDD and pstrb_i=4'b0101 -> readback 0x00BB00DD, a_mat_o[95:64]=0x00BB00DD.
- Write CONTROL=1 -> start_o high for exactly 1 cycle, busy_o=1.
  - Then write OPERAND_B row 0 -> pslverr_o=1, value unchanged.
  - Then pulse done_i with flags_i=0x5 -> busy_o=0 next cycle; FLAGS reads 0x5.
- Core writes sp_addr_i=6 with 0xFFFFFF9C -> APB read of SP at paddr_i=(6<<5)|5'b10000 returns 0xFFFFFF9C.
  - APB write to the same address -> pslverr_o=1.
- Access paddr_i[4:0]=5'b10100 -> pslverr_o=1.
  - Operand access with row index 4 and MAX_DIM=4 -> pslverr_o=1.
- Assert rst_ni low during RDWAIT -> pready_o=0 immediately; next transfer completes normally.
